// File: rtl/keypad_debounce_arbiter.sv
// Keypad front end: 2-flop sync, per-key debounce, lowest-index single-owner press arbiter.
// Optional auto-repeat while the owning key stays held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_debounce_arbiter #(
  parameter int NUM_KEYS        = 12,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] button_sw,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("keypad_debounce_arbiter: unsupported parameter set");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_HELD} state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d, stable_prev_q;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] rise;
  logic                rise_any;
  logic [3:0]          rise_idx;

  state_t              state_q;
  logic [NUM_KEYS-1:0] pulse_q;
  logic                valid_q;
  logic [3:0]          code_q;
  logic                busy_q;

  // A mismatch of sync2 against the accepted level must persist for
  // DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= button_sw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign rise = stable_q & ~stable_prev_q;

  always_comb begin
    rise_any = |rise;
    rise_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = 4'(i);
    end
  end

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int TW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  logic [TW-1:0] timer_q;
  logic          repeating_q;
`endif

  // code_q doubles as the owner index while in S_HELD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pulse_q     <= '0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      busy_q      <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      timer_q     <= '0;
      repeating_q <= 1'b0;
`endif
    end else begin
      pulse_q <= '0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise_any) begin
            pulse_q <= NUM_KEYS'(1) << rise_idx;
            valid_q <= 1'b1;
            code_q  <= rise_idx;
            busy_q  <= 1'b1;
            state_q <= S_HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
            timer_q     <= '0;
            repeating_q <= 1'b0;
`endif
          end
        end
        S_HELD: begin
          if (!stable_q[code_q]) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef KEYPAD_AUTO_REPEAT_EN
            timer_q     <= '0;
            repeating_q <= 1'b0;
          end else if (timer_q == (repeating_q ? PERIOD_LAST : DELAY_LAST)) begin
            pulse_q     <= NUM_KEYS'(1) << code_q;
            valid_q     <= 1'b1;
            timer_q     <= '0;
            repeating_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_stable = stable_q;
  assign key_pulse  = pulse_q;
  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign key_busy   = busy_q;

endmodule

// File: tb/tb_keypad_debounce_arbiter.sv
// Bench for keypad_debounce_arbiter: directed scenarios then random key activity,
// every cycle compared with a window-based reference model of the key conditioning.
module tb_keypad_debounce_arbiter;
  localparam int NK = 12;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] button_sw = '0;
  logic [NK-1:0] key_stable, key_pulse;
  logic          key_valid, key_busy;
  logic [3:0]    key_code;

  always #5 clk = ~clk;

  keypad_debounce_arbiter #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .button_sw(button_sw),
    .key_stable(key_stable), .key_pulse(key_pulse), .key_valid(key_valid),
    .key_code(key_code), .key_busy(key_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  logic [3:0] last_code = '0;

  // Reference model: raw samples delayed two edges, a key flips once its last
  // DB delayed samples all disagree with the accepted level.
  logic [NK-1:0] raw_q[$];
  logic [NK-1:0] s2_hist[$];
  logic [NK-1:0] m_stable, m_prev, m_pulse;
  logic          m_valid, m_busy;
  logic [3:0]    m_code;
  int            m_held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] rise, s2, new_stable;
    logic          all_diff;
    if (!rst) begin
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      s2_hist.delete();
      m_stable = '0; m_prev = '0; m_pulse = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_code = '0; m_held = 0;
      return;
    end
    rise    = m_stable & ~m_prev;
    m_pulse = '0;
    m_valid = 1'b0;
    if (!m_busy) begin
      if (rise != '0) begin
        for (int i = 0; i < NK; i++) begin
          if (rise[i]) begin
            m_code = 4'(i);
            break;
          end
        end
        m_pulse = NK'(1) << m_code;
        m_valid = 1'b1;
        m_busy  = 1'b1;
        m_held  = 0;
      end
    end else if (!m_stable[m_code]) begin
      m_busy = 1'b0;
    end else begin
      m_held++;
`ifdef KEYPAD_AUTO_REPEAT_EN
      if (m_held >= RD && (m_held - RD) % RP == 0) begin
        m_pulse = NK'(1) << m_code;
        m_valid = 1'b1;
      end
`endif
    end
    s2 = raw_q.pop_front();
    raw_q.push_back(button_sw);
    s2_hist.push_back(s2);
    if (s2_hist.size() > DB) void'(s2_hist.pop_front());
    new_stable = m_stable;
    if (s2_hist.size() == DB) begin
      for (int i = 0; i < NK; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (s2_hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) new_stable[i] = ~m_stable[i];
      end
    end
    m_prev   = m_stable;
    m_stable = new_stable;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("key_stable", 32'(key_stable), 32'(m_stable));
    chk("key_pulse",  32'(key_pulse),  32'(m_pulse));
    chk("key_valid",  32'(key_valid),  32'(m_valid));
    chk("key_code",   32'(key_code),   32'(m_code));
    chk("key_busy",   32'(key_busy),   32'(m_busy));
    chk("code_range", 32'(key_code < 4'(NK)), 32'd1);
    if (key_valid) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      last_code      = key_code;
    end
  endtask

  task automatic wait_pulse(input int budget, output int at);
    int start;
    start = pulse_cnt;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (pulse_cnt != start) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_stable", 32'(key_stable), 32'd0);
    chk("rst_pulse",  32'(key_pulse),  32'd0);
    chk("rst_valid",  32'(key_valid),  32'd0);
    chk("rst_code",   32'(key_code),   32'd0);
    chk("rst_busy",   32'(key_busy),   32'd0);
  endtask

  initial begin
    int t, at, n;

    // Reset
    rst = 1'b0;
    repeat (3) begin
      step();
      chk_reset_outputs();
    end
    rst = 1'b1;
    repeat (10) step();

    // 1: clean press of key 3
    button_sw[3] = 1'b1;
    t = cyc;
    wait_pulse(20, at);
    chk("t1_latency", 32'(at - t), 32'd7);
    chk("t1_code", 32'(last_code), 32'd3);
    repeat (5) step();
    chk("t1_busy_held", 32'(key_busy), 32'd1);
    button_sw[3] = 1'b0;
    repeat (12) step();
    chk("t1_busy_released", 32'(key_busy), 32'd0);

    // 2: bouncing key 5
    n = pulse_cnt;
    button_sw[5] = 1'b1; step();
    button_sw[5] = 1'b0; step();
    button_sw[5] = 1'b1; step();
    button_sw[5] = 1'b0; step();
    button_sw[5] = 1'b1;
    t = cyc;
    wait_pulse(20, at);
    chk("t2_latency", 32'(at - t), 32'd7);
    chk("t2_code", 32'(last_code), 32'd5);
    repeat (20) step();
    chk("t2_single_pulse", 32'(pulse_cnt - n), 32'd1);
    button_sw[5] = 1'b0;
    repeat (12) step();

    // 3: simultaneous keys 7 and 2
    button_sw[7] = 1'b1;
    button_sw[2] = 1'b1;
    t = cyc;
    wait_pulse(20, at);
    chk("t3_latency", 32'(at - t), 32'd7);
    chk("t3_code_low", 32'(last_code), 32'd2);
    repeat (5) step();
    button_sw[2] = 1'b0;
    n = pulse_cnt;
    repeat (15) step();
    chk("t3_no_pulse_7", 32'(pulse_cnt - n), 32'd0);
    chk("t3_idle", 32'(key_busy), 32'd0);
    button_sw[7] = 1'b0;
    repeat (10) step();
    button_sw[7] = 1'b1;
    t = cyc;
    wait_pulse(20, at);
    chk("t3_repress_latency", 32'(at - t), 32'd7);
    chk("t3_code_7", 32'(last_code), 32'd7);
    button_sw[7] = 1'b0;
    repeat (12) step();

    // 4: key 9 pressed while key 1 owns the arbiter
    button_sw[1] = 1'b1;
    wait_pulse(20, at);
    chk("t4_code", 32'(last_code), 32'd1);
    repeat (3) step();
    button_sw[9] = 1'b1;
    n = pulse_cnt;
    repeat (15) step();
    chk("t4_ignored_9", 32'(pulse_cnt - n), 32'd0);
    chk("t4_busy", 32'(key_busy), 32'd1);
    button_sw[1] = 1'b0;
    t = cyc;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!key_busy) break;
    end
    chk("t4_busy_drop", 32'(cyc - t), 32'd7);
    n = pulse_cnt;
    repeat (10) step();
    chk("t4_no_late_9", 32'(pulse_cnt - n), 32'd0);
    button_sw[9] = 1'b0;
    repeat (12) step();

    // 5: reset while key 4 is held
    button_sw[4] = 1'b1;
    wait_pulse(20, at);
    chk("t5_code_first", 32'(last_code), 32'd4);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) begin
      step();
      chk_reset_outputs();
    end
    rst = 1'b1;
    t = cyc;
    wait_pulse(20, at);
    chk("t5_latency", 32'(at - t), 32'd7);
    chk("t5_code", 32'(last_code), 32'd4);
    button_sw[4] = 1'b0;
    repeat (12) step();

    // 6: long hold of key 0
    button_sw[0] = 1'b1;
    wait_pulse(20, at);
    chk("t6_code", 32'(last_code), 32'd0);
    t = at;
    n = pulse_cnt;
    repeat (50) step();
`ifdef KEYPAD_AUTO_REPEAT_EN
    chk("t6_repeats", 32'(pulse_cnt - n), 32'd4);
    chk("t6_last_repeat", 32'(last_pulse_cyc - t), 32'd44);
`else
    chk("t6_no_repeats", 32'(pulse_cnt - n), 32'd0);
`endif
    button_sw[0] = 1'b0;
    repeat (12) step();

    // Random key activity with occasional resets
    repeat (2000) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, NK - 1);
        button_sw[n] = ~button_sw[n];
      end
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1;
    button_sw = '0;
    repeat (12) step();
    chk("final_idle", 32'(key_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_debounce_arbiter.md
Name: keypad_debounce_arbiter

Overview:
- Front-end conditioning stage for the 12-key vending button bank.
- Synchronises and debounces the raw button_sw inputs.
- Enforces single-key ownership: one registered press at a time.
- Outputs one-cycle press pulses and an encoded key code to the main control logic, in place of per-key one-shot cells.

Parameters:
- NUM_KEYS, 12: number of button inputs; the key code width is fixed at 4 bits, so NUM_KEYS must be at most 16.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a level change; minimum 2.
- REPEAT_DELAY, 25000000: cycles a key is held before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 5000000: cycles between later auto-repeat pulses (used only with the optional feature).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-low. Asserted when rst=0 at a clk rising edge.
- button_sw, input, NUM_KEYS: raw asynchronous switch levels, 1 = pressed.
- key_stable, output, NUM_KEYS: debounced level of each key.
- key_pulse, output, NUM_KEYS: one-hot, one-cycle pulse for an accepted press.
- key_valid, output, 1: high in the same cycle as any key_pulse bit.
- key_code, output, 4: index of the owning key. Valid while key_valid=1 and held through HELD.
- key_busy, output, 1: high while a key owns the arbiter (state HELD).

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-low.
- Reset values: all outputs 0, including key_code=0. All sync flops, stable bits, counters and repeat timer cleared. FSM goes to IDLE.
- Synchroniser: each key passes through a 2-flop synchroniser (sync1, then sync2).
- Debounce, per key:
  - Counter cnt[i] has width $clog2(DEBOUNCE_CYCLES).
  - If sync2[i] == key_stable[i]: cnt cleared.
  - Else, if cnt == DEBOUNCE_CYCLES-1: key_stable[i] <= sync2[i] and cnt cleared.
  - Otherwise cnt increments.
  - Any glitch that returns to the stable level before the count completes restarts the count from 0.
- Rise detect: rise[i] = key_stable[i] & ~key_stable_d[i], where key_stable_d is a registered copy of key_stable.
- Latency: for a clean step on button_sw[i] before edge 0, key_stable[i] goes high after edge DEBOUNCE_CYCLES+2. key_pulse[i] is high for exactly the one cycle after edge DEBOUNCE_CYCLES+3.
- FSM state IDLE:
  - If any rise bit is set, the lowest index i wins.
  - Register key_pulse = 1<<i, key_valid=1, key_code=i.
  - Go to HELD with owner=i.
  - Simultaneous rises: only the lowest index registers; the others are dropped and never pulse later.
- FSM state HELD:
  - key_busy=1. key_pulse and key_valid are 0, except for optional repeats.
  - Rises on other keys are ignored and discarded.
  - When key_stable[owner] becomes 0, go to IDLE the next cycle.
  - Keys still held at that point do not register; a fresh press edge is required.
- IDLE leaves key_code at its last value. key_busy=0.
- Reset mid-operation: state is discarded and stable bits return to 0. A key held through reset re-debounces and then produces a new press after DEBOUNCE_CYCLES+3 cycles from reset release.
- Inputs with index NUM_KEYS and above do not exist; key_code never exceeds NUM_KEYS-1.

Optional Feature:
- Macro: KEYPAD_AUTO_REPEAT_EN.
- When defined:
  - In HELD, a timer counts held cycles.
  - When the timer reaches REPEAT_DELAY, emit key_pulse[owner] and key_valid for one cycle.
  - After that, emit one every REPEAT_PERIOD cycles while the key stays held.
  - Timer cleared on entry to HELD, on exit from HELD, and on reset.
- When not defined: no timer logic exists, and exactly one pulse is produced per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Reset, then hold button_sw[3]=1 from cycle 10 -> key_stable[3] rises at cycle 16; key_pulse=0x008, key_valid=1, key_code=3 at cycle 17 only; key_busy=1 from cycle 17 until release.
2. Bounce button_sw[5] 1,0,1,0 at 1-cycle intervals, then hold it -> no early pulse; exactly one key_pulse[5], DEBOUNCE_CYCLES+3 cycles after the final transition.
3. Assert button_sw[7] and button_sw[2] on the same cycle -> single pulse with key_code=2; release key 2 with key 7 still held -> no pulse for key 7; release and re-press key 7 -> pulse with key_code=7.
4. Hold key 1, then press key 9 while key 1 is owned -> key 9 is ignored; key_busy stays 1 until key 1 is debounced low, then returns to 0 the next cycle.
5. Hold key 4 and pull rst=0 for 3 cycles during HELD -> all outputs 0 during reset; after reset release, one new pulse with key_code=4 at release+7.
6. With KEYPAD_AUTO_REPEAT_EN defined, hold key 0 for 50 cycles after its first pulse -> repeat pulses at +20, +28, +36, +44; without the macro -> only the initial pulse.
